lightbike_engine: RTL and testbench

LIGHTBIKE_ENGINE -- requirements
Module: lightbike_engine

---
 rtl/lightbike_if.sv | 40 ++++
 rtl/lightbike_engine.sv | 250 +++++++++++++++++++++++++
 tb/tb_lightbike_engine.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lightbike_if.sv
// Control, steering and pixel-read signals of the two-player lightbike engine.
// The engine side uses the slave modport; the driver side uses master.
interface lightbike_if #(
   parameter int XW = 5,
   parameter int YW = 5,
   parameter int SW = 4
);
   logic          tick;
   logic          start;
   logic          ack;
   logic [1:0]    p1_dir;
   logic          p1_dir_vld;
   logic [1:0]    p2_dir;
   logic          p2_dir_vld;
   logic [XW-1:0] rd_x;
   logic [YW-1:0] rd_y;
   logic          rd_trail;
   logic          rd_p1_head;
   logic          rd_p2_head;
   logic [4:0]    state;
   logic [SW-1:0] p1_score;
   logic [SW-1:0] p2_score;
   logic [1:0]    winner;

   modport master (
      output tick, start, ack,
      output p1_dir, p1_dir_vld, p2_dir, p2_dir_vld,
      output rd_x, rd_y,
      input  rd_trail, rd_p1_head, rd_p2_head,
      input  state, p1_score, p2_score, winner
   );

   modport slave (
      input  tick, start, ack,
      input  p1_dir, p1_dir_vld, p2_dir, p2_dir_vld,
      input  rd_x, rd_y,
      output rd_trail, rd_p1_head, rd_p2_head,
      output state, p1_score, p2_score, winner
   );
endinterface

// File: rtl/lightbike_engine.sv
// Two-player lightbike game: occupancy grid with border, per-tick movement,
// crash detection, round scoring and a registered pixel-read port.
module lightbike_engine #(
   parameter int GRID_W    = 32,
   parameter int GRID_H    = 32,
   parameter int XW        = 5,
   parameter int YW        = 5,
   parameter int SCORE_MAX = 3,
   parameter int SW        = 4
) (
   input  logic       clk,
   input  logic       reset,
   lightbike_if.slave bus
);

   typedef enum logic [4:0] {
      ST_CLEAR   = 5'b00001,
      ST_READY   = 5'b00010,
      ST_DRIVING = 5'b00100,
      ST_CRASH   = 5'b01000,
      ST_OVER    = 5'b10000
   } state_t;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_DOWN  = 2'd1;
   localparam dir_t DIR_LEFT  = 2'd2;
   localparam dir_t DIR_RIGHT = 2'd3;

   localparam logic [XW-1:0]     P1_X0     = XW'(GRID_W / 4);
   localparam logic [XW-1:0]     P2_X0     = XW'(3 * GRID_W / 4 - 1);
   localparam logic [YW-1:0]     START_Y   = YW'(GRID_H / 2);
   localparam logic [YW-1:0]     LAST_ROW  = YW'(GRID_H - 1);
   localparam logic [SW-1:0]     SCORE_TOP = SW'(SCORE_MAX);
   localparam logic [GRID_W-1:0] ROW_SOLID = '1;
   localparam logic [GRID_W-1:0] ROW_SIDES = {1'b1, {(GRID_W-2){1'b0}}, 1'b1};

   // Up/down share bit1 = 0, left/right share bit1 = 1; reversal flips bit0.
   function automatic logic is_reverse(input dir_t a, input dir_t b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

   function automatic logic [XW-1:0] step_x(input logic [XW-1:0] x, input dir_t d);
      logic [XW-1:0] r;
      r = x;
      if (d == DIR_LEFT)  r = x - XW'(1);
      if (d == DIR_RIGHT) r = x + XW'(1);
      return r;
   endfunction

   function automatic logic [YW-1:0] step_y(input logic [YW-1:0] y, input dir_t d);
      logic [YW-1:0] r;
      r = y;
      if (d == DIR_UP)   r = y - YW'(1);
      if (d == DIR_DOWN) r = y + YW'(1);
      return r;
   endfunction

   function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] s);
      return (s == SCORE_TOP) ? s : s + SW'(1);
   endfunction

   state_t              state_q, state_d;
   logic [YW-1:0]       row_q, row_d;
   logic [GRID_W-1:0]   grid_q [GRID_H];
   logic [GRID_W-1:0]   grid_d [GRID_H];
   logic [XW-1:0]       p1_x_q, p1_x_d, p2_x_q, p2_x_d;
   logic [YW-1:0]       p1_y_q, p1_y_d, p2_y_q, p2_y_d;
   dir_t                p1_dir_q, p1_dir_d, p2_dir_q, p2_dir_d;
   dir_t                p1_pend_q, p1_pend_d, p2_pend_q, p2_pend_d;
   logic [SW-1:0]       p1_score_q, p1_score_d, p2_score_q, p2_score_d;
   logic [1:0]          winner_q, winner_d;
   logic                rd_trail_q, rd_trail_d;
   logic                rd_p1_head_q, rd_p1_head_d;
   logic                rd_p2_head_q, rd_p2_head_d;

   logic                enter_clear;
   logic [XW-1:0]       n1_x, n2_x;
   logic [YW-1:0]       n1_y, n2_y;
   logic                p1_occ, p2_occ, same_cell, swap_cells;
   logic                p1_crash, p2_crash;
   logic                rd_in_grid;

   // Next heads use the pending direction, which becomes current on this tick.
   assign n1_x = step_x(p1_x_q, p1_pend_q);
   assign n1_y = step_y(p1_y_q, p1_pend_q);
   assign n2_x = step_x(p2_x_q, p2_pend_q);
   assign n2_y = step_y(p2_y_q, p2_pend_q);

   // Occupancy is judged before this tick's head marks land in the grid.
   assign p1_occ     = grid_q[n1_y][n1_x];
   assign p2_occ     = grid_q[n2_y][n2_x];
   assign same_cell  = (n1_x == n2_x) && (n1_y == n2_y);
   assign swap_cells = (n1_x == p2_x_q) && (n1_y == p2_y_q) &&
                       (n2_x == p1_x_q) && (n2_y == p1_y_q);
   assign p1_crash   = p1_occ | same_cell | swap_cells;
   assign p2_crash   = p2_occ | same_cell | swap_cells;

   always_comb begin
      state_d     = state_q;
      row_d       = row_q;
      grid_d      = grid_q;
      p1_x_d      = p1_x_q;
      p1_y_d      = p1_y_q;
      p2_x_d      = p2_x_q;
      p2_y_d      = p2_y_q;
      p1_dir_d    = p1_dir_q;
      p2_dir_d    = p2_dir_q;
      p1_pend_d   = p1_pend_q;
      p2_pend_d   = p2_pend_q;
      p1_score_d  = p1_score_q;
      p2_score_d  = p2_score_q;
      winner_d    = winner_q;
      enter_clear = 1'b0;

      case (state_q)
         ST_CLEAR: begin
            grid_d[row_q] = (row_q == '0 || row_q == LAST_ROW) ? ROW_SOLID : ROW_SIDES;
            row_d         = row_q + YW'(1);
            if (row_q == LAST_ROW) state_d = ST_READY;
         end
         ST_READY: begin
            if (bus.start) state_d = ST_DRIVING;
         end
         ST_DRIVING: begin
            if (bus.tick) begin
               p1_dir_d               = p1_pend_q;
               p2_dir_d               = p2_pend_q;
               grid_d[p1_y_q][p1_x_q] = 1'b1;
               grid_d[p2_y_q][p2_x_q] = 1'b1;
               if (p1_crash || p2_crash) begin
                  state_d = ST_CRASH;
                  if (!p1_crash) begin
                     winner_d   = 2'b01;
                     p1_score_d = sat_inc(p1_score_q);
                  end else if (!p2_crash) begin
                     winner_d   = 2'b10;
                     p2_score_d = sat_inc(p2_score_q);
                  end else begin
                     winner_d   = 2'b11;
                  end
               end else begin
                  p1_x_d = n1_x;
                  p1_y_d = n1_y;
                  p2_x_d = n2_x;
                  p2_y_d = n2_y;
               end
            end
         end
         ST_CRASH: begin
            if (bus.ack) begin
               if (p1_score_q == SCORE_TOP || p2_score_q == SCORE_TOP) state_d = ST_OVER;
               else enter_clear = 1'b1;
            end
         end
         ST_OVER: begin
            if (bus.ack) begin
               p1_score_d  = '0;
               p2_score_d  = '0;
               enter_clear = 1'b1;
            end
         end
         default: enter_clear = 1'b1;
      endcase

      if (enter_clear) begin
         state_d   = ST_CLEAR;
         row_d     = '0;
         p1_x_d    = P1_X0;
         p1_y_d    = START_Y;
         p2_x_d    = P2_X0;
         p2_y_d    = START_Y;
         p1_dir_d  = DIR_RIGHT;
         p2_dir_d  = DIR_LEFT;
         p1_pend_d = DIR_RIGHT;
         p2_pend_d = DIR_LEFT;
         winner_d  = 2'b00;
      end

      // Requests are screened against the direction in force after this cycle.
      if (bus.p1_dir_vld && !is_reverse(bus.p1_dir, p1_dir_d)) p1_pend_d = bus.p1_dir;
      if (bus.p2_dir_vld && !is_reverse(bus.p2_dir, p2_dir_d)) p2_pend_d = bus.p2_dir;
   end

   assign rd_in_grid = (int'(bus.rd_x) < GRID_W) && (int'(bus.rd_y) < GRID_H);

   always_comb begin
      rd_trail_d   = 1'b0;
      rd_p1_head_d = 1'b0;
      rd_p2_head_d = 1'b0;
      if (rd_in_grid) begin
         rd_trail_d   = grid_q[bus.rd_y][bus.rd_x];
         rd_p1_head_d = (bus.rd_x == p1_x_q) && (bus.rd_y == p1_y_q);
         rd_p2_head_d = (bus.rd_x == p2_x_q) && (bus.rd_y == p2_y_q);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_CLEAR;
         row_q        <= '0;
         p1_x_q       <= P1_X0;
         p1_y_q       <= START_Y;
         p2_x_q       <= P2_X0;
         p2_y_q       <= START_Y;
         p1_dir_q     <= DIR_RIGHT;
         p2_dir_q     <= DIR_LEFT;
         p1_pend_q    <= DIR_RIGHT;
         p2_pend_q    <= DIR_LEFT;
         p1_score_q   <= '0;
         p2_score_q   <= '0;
         winner_q     <= 2'b00;
         rd_trail_q   <= 1'b0;
         rd_p1_head_q <= 1'b0;
         rd_p2_head_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         p1_x_q       <= p1_x_d;
         p1_y_q       <= p1_y_d;
         p2_x_q       <= p2_x_d;
         p2_y_q       <= p2_y_d;
         p1_dir_q     <= p1_dir_d;
         p2_dir_q     <= p2_dir_d;
         p1_pend_q    <= p1_pend_d;
         p2_pend_q    <= p2_pend_d;
         p1_score_q   <= p1_score_d;
         p2_score_q   <= p2_score_d;
         winner_q     <= winner_d;
         rd_trail_q   <= rd_trail_d;
         rd_p1_head_q <= rd_p1_head_d;
         rd_p2_head_q <= rd_p2_head_d;
      end
   end

   // Grid contents are rebuilt by CLEAR after every reset, so they carry no reset.
   always_ff @(posedge clk) begin
      grid_q <= grid_d;
   end

   assign bus.state      = state_q;
   assign bus.p1_score   = p1_score_q;
   assign bus.p2_score   = p2_score_q;
   assign bus.winner     = winner_q;
   assign bus.rd_trail   = rd_trail_q;
   assign bus.rd_p1_head = rd_p1_head_q;
   assign bus.rd_p2_head = rd_p2_head_q;

endmodule

// File: tb/tb_lightbike_engine.sv
// Bench for lightbike_engine: directed game scenarios plus random play,
// all outputs compared every cycle against a cell-level game model.
module tb_lightbike_engine;
   localparam int GRID_W    = 32;
   localparam int GRID_H    = 32;
   localparam int XW        = 5;
   localparam int YW        = 5;
   localparam int SCORE_MAX = 3;
   localparam int SW        = 4;

   localparam int PH_CLEAR = 0;
   localparam int PH_READY = 1;
   localparam int PH_DRIVE = 2;
   localparam int PH_CRASH = 3;
   localparam int PH_OVER  = 4;

   logic clk = 1'b0;
   logic rst;

   lightbike_if #(.XW(XW), .YW(YW), .SW(SW)) bus ();

   lightbike_engine #(
      .GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW),
      .SCORE_MAX(SCORE_MAX), .SW(SW)
   ) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Game model: plain cell array, coordinates and counters.
   bit m_grid [GRID_H][GRID_W];
   int m_phase, m_clr;
   int h1x, h1y, h2x, h2y, d1, d2, q1, q2, s1, s2, win;
   int e_trail, e_h1, e_h2;
   bit rd_chk;
   int dx  [4] = '{0, 0, -1, 1};
   int dy  [4] = '{-1, 1, 0, 0};
   int opp [4] = '{1, 0, 3, 2};

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic new_round();
      m_phase = PH_CLEAR;
      m_clr   = 0;
      h1x = GRID_W / 4;         h1y = GRID_H / 2;
      h2x = 3 * GRID_W / 4 - 1; h2y = GRID_H / 2;
      d1 = 3; d2 = 2; q1 = 3; q2 = 2;
      win = 0;
   endtask

   task automatic model_step();
      int n1x, n1y, n2x, n2y;
      bit c1, c2;
      rd_chk = rst || (m_phase != PH_CLEAR);
      if (rst) begin
         e_trail = 0; e_h1 = 0; e_h2 = 0;
         new_round();
         s1 = 0; s2 = 0;
      end else begin
         e_trail = m_grid[bus.rd_y][bus.rd_x];
         e_h1 = (int'(bus.rd_x) == h1x && int'(bus.rd_y) == h1y);
         e_h2 = (int'(bus.rd_x) == h2x && int'(bus.rd_y) == h2y);
         case (m_phase)
            PH_CLEAR: begin
               m_clr++;
               if (m_clr == GRID_H) begin
                  for (int y = 0; y < GRID_H; y++)
                     for (int x = 0; x < GRID_W; x++)
                        m_grid[y][x] = (x == 0 || y == 0 || x == GRID_W-1 || y == GRID_H-1);
                  m_phase = PH_READY;
               end
            end
            PH_READY: if (bus.start) m_phase = PH_DRIVE;
            PH_DRIVE: if (bus.tick) begin
               d1 = q1; d2 = q2;
               n1x = h1x + dx[d1]; n1y = h1y + dy[d1];
               n2x = h2x + dx[d2]; n2y = h2y + dy[d2];
               c1 = m_grid[n1y][n1x] || (n1x == n2x && n1y == n2y) ||
                    (n1x == h2x && n1y == h2y && n2x == h1x && n2y == h1y);
               c2 = m_grid[n2y][n2x] || (n1x == n2x && n1y == n2y) ||
                    (n1x == h2x && n1y == h2y && n2x == h1x && n2y == h1y);
               m_grid[h1y][h1x] = 1'b1;
               m_grid[h2y][h2x] = 1'b1;
               if (c1 || c2) begin
                  m_phase = PH_CRASH;
                  if (c1 && c2) win = 3;
                  else if (c2) begin win = 1; if (s1 < SCORE_MAX) s1++; end
                  else begin win = 2; if (s2 < SCORE_MAX) s2++; end
               end else begin
                  h1x = n1x; h1y = n1y; h2x = n2x; h2y = n2y;
               end
            end
            PH_CRASH: if (bus.ack) begin
               if (s1 == SCORE_MAX || s2 == SCORE_MAX) m_phase = PH_OVER;
               else new_round();
            end
            PH_OVER: if (bus.ack) begin
               s1 = 0; s2 = 0;
               new_round();
            end
            default: ;
         endcase
         if (bus.p1_dir_vld && int'(bus.p1_dir) != opp[d1]) q1 = int'(bus.p1_dir);
         if (bus.p2_dir_vld && int'(bus.p2_dir) != opp[d2]) q2 = int'(bus.p2_dir);
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      chk("state", bus.state, 1 << m_phase);
      chk("p1_score", bus.p1_score, s1);
      chk("p2_score", bus.p2_score, s2);
      chk("winner", bus.winner, win);
      chk("rd_p1_head", bus.rd_p1_head, e_h1);
      chk("rd_p2_head", bus.rd_p2_head, e_h2);
      if (rd_chk) chk("rd_trail", bus.rd_trail, e_trail);
   endtask

   task automatic do_tick();
      bus.tick = 1'b1; step();
      bus.tick = 1'b0; step();
   endtask

   task automatic wait_state(input logic [4:0] target, input string tag);
      int n = 0;
      while (bus.state !== target && n < 200) begin
         step();
         n++;
      end
      chk(tag, bus.state, target);
   endtask

   task automatic pulse_ack();
      bus.ack = 1'b1; step();
      bus.ack = 1'b0;
   endtask

   // p1 steers up, p2 steers down; p2 meets the bottom wall on tick 15.
   task automatic p1_win_round(input int exp_score);
      bus.p1_dir = 2'd0; bus.p1_dir_vld = 1'b1;
      bus.p2_dir = 2'd1; bus.p2_dir_vld = 1'b1;
      step();
      bus.p1_dir_vld = 1'b0; bus.p2_dir_vld = 1'b0;
      bus.start = 1'b1; step();
      bus.start = 1'b0;
      for (int i = 0; i < 14; i++) do_tick();
      chk("drive_before_15", bus.state, 5'b00100);
      do_tick();
      chk("crash_state", bus.state, 5'b01000);
      chk("p1_win", bus.winner, 2'b01);
      chk("p1_score_n", bus.p1_score, exp_score);
      bus.rd_x = 5'd8; bus.rd_y = 5'd2; step();
      chk("p1_head_8_2", bus.rd_p1_head, 1);
   endtask

   initial begin
      int n;
      rst = 1'b0;
      bus.tick = 1'b0; bus.start = 1'b0; bus.ack = 1'b0;
      bus.p1_dir = 2'd0; bus.p1_dir_vld = 1'b0;
      bus.p2_dir = 2'd0; bus.p2_dir_vld = 1'b0;
      bus.rd_x = '0; bus.rd_y = '0;
      new_round();
      s1 = 0; s2 = 0;

      // Reset, CLEAR length and border contents
      rst = 1'b1; step();
      rst = 1'b0;
      n = 0;
      while (bus.state == 5'b00001 && n < 100) begin
         n++;
         step();
      end
      chk("clear_len", n, 32);
      chk("ready_after_clear", bus.state, 5'b00010);
      bus.rd_x = 5'd0; bus.rd_y = 5'd5; step();
      chk("trail_0_5", bus.rd_trail, 1);
      bus.rd_x = 5'd5; step();
      chk("trail_5_5", bus.rd_trail, 0);

      // Head-on swap crash, with a discarded reverse request
      bus.start = 1'b1; step();
      bus.start = 1'b0;
      chk("driving", bus.state, 5'b00100);
      bus.p1_dir = 2'd2; bus.p1_dir_vld = 1'b1; step();
      bus.p1_dir_vld = 1'b0;
      do_tick();
      bus.rd_x = 5'd9; bus.rd_y = 5'd16; step();
      chk("reverse_ignored", bus.rd_p1_head, 1);
      for (int i = 0; i < 6; i++) do_tick();
      chk("drive_after_7", bus.state, 5'b00100);
      do_tick();
      chk("swap_crash", bus.state, 5'b01000);
      chk("swap_winner", bus.winner, 2'b11);
      chk("swap_p1_score", bus.p1_score, 0);
      chk("swap_p2_score", bus.p2_score, 0);
      bus.rd_x = 5'd15; bus.rd_y = 5'd16; step();
      chk("swap_p1_head", bus.rd_p1_head, 1);
      bus.rd_x = 5'd16; step();
      chk("swap_p2_head", bus.rd_p2_head, 1);

      // Three p1 wins end the match
      pulse_ack();
      chk("crash_to_clear", bus.state, 5'b00001);
      for (int r = 1; r <= 3; r++) begin
         wait_state(5'b00010, "wait_ready");
         p1_win_round(r);
         if (r < 3) pulse_ack();
      end
      pulse_ack();
      chk("match_over", bus.state, 5'b10000);
      chk("over_p1_score", bus.p1_score, 3);
      pulse_ack();
      chk("over_to_clear", bus.state, 5'b00001);
      chk("scores_zeroed", bus.p1_score, 0);

      // Reset during a driving tick
      wait_state(5'b00010, "wait_ready");
      p1_win_round(1);
      pulse_ack();
      wait_state(5'b00010, "wait_ready");
      bus.start = 1'b1; step();
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) do_tick();
      rst = 1'b1; bus.tick = 1'b1; step();
      rst = 1'b0; bus.tick = 1'b0;
      chk("reset_to_clear", bus.state, 5'b00001);
      chk("reset_score", bus.p1_score, 0);
      wait_state(5'b00010, "wait_ready");
      n = 0;
      for (int y = 1; y < GRID_H - 1; y++)
         for (int x = 1; x < GRID_W - 1; x++) begin
            bus.rd_x = XW'(x); bus.rd_y = YW'(y);
            step();
            if (bus.rd_trail) n++;
         end
      chk("interior_empty", n, 0);

      // Random play against the model
      for (int c = 0; c < 15000; c++) begin
         rst            = ($urandom_range(0, 1999) == 0);
         bus.tick       = ($urandom_range(0, 3) == 0);
         bus.start      = ($urandom_range(0, 7) == 0);
         bus.ack        = ($urandom_range(0, 15) == 0);
         bus.p1_dir_vld = ($urandom_range(0, 5) == 0);
         bus.p1_dir     = 2'($urandom_range(0, 3));
         bus.p2_dir_vld = ($urandom_range(0, 5) == 0);
         bus.p2_dir     = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       begin bus.rd_x = XW'(h1x); bus.rd_y = YW'(h1y); end
            1:       begin bus.rd_x = XW'(h2x); bus.rd_y = YW'(h2y); end
            default: begin bus.rd_x = XW'($urandom_range(0, GRID_W-1));
                           bus.rd_y = YW'($urandom_range(0, GRID_H-1)); end
         endcase
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
